// File: rtl/ils_decode_pkg.sv
// Shared decode types for the ILS instruction monitor: class encoding, opcodes and the
// pure decode function that turns a raw RV32I word into a field record.
package ils_decode_pkg;

  typedef enum logic [1:0] {
    CLS_ALUI    = 2'd0,
    CLS_LOAD    = 2'd1,
    CLS_STORE   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } ils_class_e;

  localparam logic [6:0]  OPC_ALUI  = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    ils_class_e  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        is_nop;
  } ils_rec_t;

  function automatic ils_rec_t decode(input logic [31:0] instr);
    ils_rec_t   rec;
    logic [2:0] f3;
    logic [6:0] hi7;
    logic       legal;
    f3         = instr[14:12];
    hi7        = instr[31:25];
    rec.cls    = CLS_ILLEGAL;
    rec.rd     = instr[11:7];
    rec.rs1    = instr[19:15];
    rec.rs2    = instr[24:20];
    rec.funct3 = f3;
    rec.imm    = 32'h0;
    rec.is_nop = (instr == INSTR_NOP);
    legal      = 1'b0;
    case (instr[6:0])
      OPC_ALUI: begin
        // Shift-immediates reuse imm[11:5] as funct7; only the defined encodings are legal.
        case (f3)
          3'd1:    legal = (hi7 == 7'h00);
          3'd5:    legal = (hi7 == 7'h00) || (hi7 == 7'h20);
          default: legal = 1'b1;
        endcase
        if (legal) begin
          rec.cls = CLS_ALUI;
          rec.rs2 = 5'd0;
          rec.imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LOAD: begin
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (legal) begin
          rec.cls = CLS_LOAD;
          rec.rs2 = 5'd0;
          rec.imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        if (legal) begin
          rec.cls = CLS_STORE;
          rec.rd  = 5'd0;
          rec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
      end
      default: legal = 1'b0;
    endcase
    return rec;
  endfunction

endpackage

// File: rtl/ils_skid_buf.sv
// Two-entry valid/ready buffer carrying decoded records at full throughput with a registered in_ready.
//  state | meaning
//  EMPTY | no record held, out_valid low
//  ONE   | head holds the oldest record
//  FULL  | head and tail both hold records, in_ready low
module ils_skid_buf
  import ils_decode_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  ils_rec_t in_rec,
  output logic     out_valid,
  input  logic     out_ready,
  output ils_rec_t out_rec
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  buf_state_e state, state_nxt;
  ils_rec_t   head_q, tail_q;
  logic       in_ready_q;
  logic       accept, retire;
  logic       load_head, head_from_tail, load_tail;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_rec   = head_q;
  assign accept    = in_valid && in_ready_q;
  assign retire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  always_comb begin
    state_nxt      = state;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (accept && retire) begin
          load_head = 1'b1;
        end else if (accept) begin
          load_tail = 1'b1;
          state_nxt = FULL;
        end else if (retire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          load_head      = 1'b1;
          head_from_tail = 1'b1;
          if (accept) load_tail = 1'b1;
          else        state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) head_q <= head_from_tail ? tail_q : in_rec;
      if (load_tail) tail_q <= in_rec;
    end
  end

endmodule

// File: rtl/ils_instr_decoder.sv
// ILS decode/retire monitor: decodes each accepted word, buffers it through a 2-entry skid
// buffer and keeps saturating per-class retire counters.
module ils_instr_decoder
  import ils_decode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [31:0]      out_imm,
  output logic             out_is_nop,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_alui,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_illegal,
  output logic [CNT_W-1:0] cnt_nop
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ils_rec_t in_rec, out_rec;
  logic     retire;

  assign in_rec = decode(in_instr);

  ils_skid_buf u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rec   (out_rec)
  );

  assign out_class  = out_rec.cls;
  assign out_rd     = out_rec.rd;
  assign out_rs1    = out_rec.rs1;
  assign out_rs2    = out_rec.rs2;
  assign out_funct3 = out_rec.funct3;
  assign out_imm    = out_rec.imm;
  assign out_is_nop = out_rec.is_nop;

  assign retire = out_valid && out_ready;

  // Clear wins, but a retire in the same cycle is still counted.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur, input logic hit,
                                                input logic clr);
    if (clr)               return hit ? CNT_ONE : '0;
    if (hit && !(&cur))    return cur + CNT_ONE;
    return cur;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_alui    <= '0;
      cnt_load    <= '0;
      cnt_store   <= '0;
      cnt_illegal <= '0;
      cnt_nop     <= '0;
    end else begin
      cnt_alui    <= cnt_next(cnt_alui,    retire && (out_rec.cls == CLS_ALUI),    cnt_clear);
      cnt_load    <= cnt_next(cnt_load,    retire && (out_rec.cls == CLS_LOAD),    cnt_clear);
      cnt_store   <= cnt_next(cnt_store,   retire && (out_rec.cls == CLS_STORE),   cnt_clear);
      cnt_illegal <= cnt_next(cnt_illegal, retire && (out_rec.cls == CLS_ILLEGAL), cnt_clear);
      cnt_nop     <= cnt_next(cnt_nop,
                              retire && (out_rec.cls == CLS_ALUI) && out_rec.is_nop, cnt_clear);
    end
  end

endmodule

// File: tb/tb_ils_instr_decoder.sv
// Directed bench for ils_instr_decoder: decode vectors, back-pressure streaming, counter saturation/clear, reset.
module tb_ils_instr_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic        out_valid, out_ready;
  logic [1:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;
  logic        out_is_nop;
  logic        cnt_clear;
  logic [3:0]  cnt_alui, cnt_load, cnt_store, cnt_illegal, cnt_nop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ils_instr_decoder #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_imm(out_imm),
    .out_is_nop(out_is_nop), .cnt_clear(cnt_clear), .cnt_alui(cnt_alui), .cnt_load(cnt_load),
    .cnt_store(cnt_store), .cnt_illegal(cnt_illegal), .cnt_nop(cnt_nop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for exactly one edge (caller ensures in_ready is high).
  task automatic issue(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; cnt_clear = 1'b0;
    #2 reset_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
    end
    n_checks++;
    if ({out_class, out_rd, out_rs1, out_rs2, out_funct3, out_imm, out_is_nop} !== '0) begin
      n_errors++; $display("FAIL reset_fields: imm=%h class=%0d, want all zero", out_imm, out_class);
    end
    n_checks++;
    if ({cnt_alui, cnt_load, cnt_store, cnt_illegal, cnt_nop} !== '0) begin
      n_errors++; $display("FAIL reset_cnt: alui=%0d load=%0d, want 0", cnt_alui, cnt_load);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_nop();
    out_ready = 1'b1;
    issue(32'h0000_0013);
    n_checks++;
    if (out_valid !== 1'b1 || out_class !== 2'd0 || out_is_nop !== 1'b1 || out_imm !== 32'h0 ||
        out_rd !== 5'd0 || out_rs1 !== 5'd0) begin
      n_errors++;
      $display("FAIL nop_decode: v=%b class=%0d nop=%b imm=%h rd=%0d rs1=%0d, want 1 0 1 0 0 0",
               out_valid, out_class, out_is_nop, out_imm, out_rd, out_rs1);
    end
    tick();
    n_checks++;
    if (cnt_alui !== 4'd1 || cnt_nop !== 4'd1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL nop_count: alui=%0d nop=%0d v=%b, want 1 1 0", cnt_alui, cnt_nop, out_valid);
    end
  endtask

  task automatic test_load();
    issue(32'h8000_C103);
    n_checks++;
    if (out_class !== 2'd1 || out_rd !== 5'd2 || out_rs1 !== 5'd1 || out_funct3 !== 3'd4 ||
        out_imm !== 32'hFFFF_F800 || out_rs2 !== 5'd0 || out_is_nop !== 1'b0) begin
      n_errors++;
      $display("FAIL load_decode: class=%0d rd=%0d rs1=%0d f3=%0d imm=%h rs2=%0d, want 1 2 1 4 fffff800 0",
               out_class, out_rd, out_rs1, out_funct3, out_imm, out_rs2);
    end
    tick();
    n_checks++;
    if (cnt_load !== 4'd1) begin
      n_errors++; $display("FAIL load_count: cnt_load=%0d, want 1", cnt_load);
    end
  endtask

  task automatic test_store();
    issue(32'h7E32_0FA3);
    n_checks++;
    if (out_class !== 2'd2 || out_rs1 !== 5'd4 || out_rs2 !== 5'd3 || out_rd !== 5'd0 ||
        out_funct3 !== 3'd0 || out_imm !== 32'h0000_07FF) begin
      n_errors++;
      $display("FAIL store_decode: class=%0d rs1=%0d rs2=%0d rd=%0d f3=%0d imm=%h, want 2 4 3 0 0 000007ff",
               out_class, out_rs1, out_rs2, out_rd, out_funct3, out_imm);
    end
    tick();
    n_checks++;
    if (cnt_store !== 4'd1) begin
      n_errors++; $display("FAIL store_count: cnt_store=%0d, want 1", cnt_store);
    end
  endtask

  task automatic test_shift_legality();
    issue(32'h4000_9093);
    n_checks++;
    if (out_class !== 2'd3 || out_imm !== 32'h0) begin
      n_errors++; $display("FAIL slli_illegal: class=%0d imm=%h, want 3 0", out_class, out_imm);
    end
    tick();
    issue(32'h4000_D093);
    n_checks++;
    if (out_class !== 2'd0 || out_imm !== 32'h0000_0400 || out_funct3 !== 3'd5 ||
        out_rd !== 5'd1 || out_rs1 !== 5'd1) begin
      n_errors++;
      $display("FAIL srai_legal: class=%0d imm=%h f3=%0d rd=%0d rs1=%0d, want 0 00000400 5 1 1",
               out_class, out_imm, out_funct3, out_rd, out_rs1);
    end
    tick();
    n_checks++;
    if (cnt_illegal !== 4'd1 || cnt_alui !== 4'd2 || cnt_nop !== 4'd1) begin
      n_errors++;
      $display("FAIL shift_counts: illegal=%0d alui=%0d nop=%0d, want 1 2 1", cnt_illegal, cnt_alui, cnt_nop);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [8];
    int sent = 0, rcvd = 0, cyc = 0;
    logic acc, ret;
    for (int i = 0; i < 8; i++)
      words[i] = {12'(i * 3 + 1), 5'd0, 3'b000, 5'(i + 1), 7'h13};
    while (rcvd < 8 && cyc < 60) begin
      in_valid  = (sent < 8);
      in_instr  = (sent < 8) ? words[sent] : 32'h0;
      out_ready = (cyc >= 3);
      if (cyc == 2) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'd1) begin
          n_errors++;
          $display("FAIL bp_full: in_ready=%b out_valid=%b imm=%h, want 0 1 00000001",
                   in_ready, out_valid, out_imm);
        end
      end
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        n_checks++;
        if (out_class !== 2'd0 || out_rd !== 5'(rcvd + 1) || out_imm !== 32'(rcvd * 3 + 1)) begin
          n_errors++;
          $display("FAIL bp_order[%0d]: class=%0d rd=%0d imm=%h, want 0 %0d %h",
                   rcvd, out_class, out_rd, out_imm, rcvd + 1, 32'(rcvd * 3 + 1));
        end
      end
      tick();
      if (acc) sent++;
      if (ret) rcvd++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (rcvd != 8) begin
      n_errors++; $display("FAIL bp_count: received %0d records, want 8", rcvd);
    end
    n_checks++;
    if (cnt_alui !== 4'd10) begin
      n_errors++; $display("FAIL bp_cnt_alui: cnt_alui=%0d, want 10", cnt_alui);
    end
  endtask

  task automatic test_counters();
    int sent = 0, rcvd = 0, cyc = 0;
    logic acc, ret;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_checks++;
    if ({cnt_alui, cnt_load, cnt_store, cnt_illegal, cnt_nop} !== '0) begin
      n_errors++; $display("FAIL cnt_clear: alui=%0d load=%0d store=%0d, want 0", cnt_alui, cnt_load, cnt_store);
    end
    out_ready = 1'b1;
    while (rcvd < 17 && cyc < 80) begin
      in_valid = (sent < 17);
      in_instr = 32'h0010_0093;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      tick();
      if (acc) sent++;
      if (ret) rcvd++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (rcvd != 17 || cnt_alui !== 4'd15 || cnt_nop !== 4'd0) begin
      n_errors++;
      $display("FAIL cnt_saturate: rcvd=%0d alui=%0d nop=%0d, want 17 15 0", rcvd, cnt_alui, cnt_nop);
    end
    out_ready = 1'b0;
    issue(32'h0010_0093);
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_checks++;
    if (cnt_alui !== 4'd1 || cnt_load !== 4'd0 || cnt_illegal !== 4'd0) begin
      n_errors++;
      $display("FAIL clear_with_retire: alui=%0d load=%0d illegal=%0d, want 1 0 0", cnt_alui, cnt_load, cnt_illegal);
    end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    issue(32'h0010_0093);
    issue(32'h0020_0113);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== 32'h0 || cnt_alui !== 4'd0) begin
      n_errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b imm=%h alui=%0d, want 0 0 0 0",
               out_valid, in_ready, out_imm, cnt_alui);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_recover: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    issue(32'h8000_C103);
    n_checks++;
    if (out_valid !== 1'b1 || out_class !== 2'd1 || out_rd !== 5'd2) begin
      n_errors++;
      $display("FAIL mid_reset_fresh: v=%b class=%0d rd=%0d, want 1 1 2", out_valid, out_class, out_rd);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || cnt_load !== 4'd1) begin
      n_errors++; $display("FAIL mid_reset_drained: v=%b load=%0d, want 0 1", out_valid, cnt_load);
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_load();
    test_store();
    test_shift_legality();
    test_back_to_back();
    test_counters();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
